// File: rtl/break_fetch_sequencer_pkg.sv
// break_fetch_sequencer_pkg: shared sizes, FSM states and wren slot codes for the break fetch sequencer
package break_fetch_sequencer_pkg;
  localparam int MC = 20;
  localparam int NSAT = 3;
  localparam int NSAT_BITS = 2;
  localparam int VAR_BITS = 12;
  typedef enum logic [2:0] {IDLE, RD0, LD1, LD2, LD3, DONE} state_t;
  localparam logic [NSAT_BITS-1:0] WREN_NONE = 2'b00;
  localparam logic [NSAT_BITS-1:0] WREN_S1 = 2'b01;
  localparam logic [NSAT_BITS-1:0] WREN_S2 = 2'b10;
  localparam logic [NSAT_BITS-1:0] WREN_S3 = 2'b11;
  function automatic logic [VAR_BITS-1:0] slot_var(input logic [NSAT*VAR_BITS-1:0] v, input logic [1:0] k);
    return v[k*VAR_BITS +: VAR_BITS];
  endfunction
  function automatic logic has_short(input logic [NSAT*VAR_BITS-1:0] v);
    return slot_var(v, 2'd0) == '0 || slot_var(v, 2'd1) == '0 || slot_var(v, 2'd2) == '0;
  endfunction
endpackage

// File: rtl/break_fetch_sequencer_if.sv
// break_fetch_sequencer_if: candidate handshake, clause memory bus and selector load bus (stats ports with BFS_STATS_EN)
interface break_fetch_sequencer_if;
  import break_fetch_sequencer_pkg::*;
  logic cand_valid_i;
  logic cand_ready_o;
  logic [NSAT*VAR_BITS-1:0] cand_vars_i;
  logic mem_rd_o;
  logic [VAR_BITS-1:0] mem_addr_o;
  logic [MC-1:0] mem_break_i;
  logic [MC-1:0] mem_mask_i;
  logic [MC-1:0] clause_broken_o;
  logic [MC-1:0] mask_bits_o;
  logic [NSAT_BITS-1:0] wren_o;
  logic [NSAT-1:0] break_values_valid_o;
  logic result_ready_o;
`ifdef BFS_STATS_EN
  logic [31:0] stats_sets_o;
  logic [31:0] stats_short_o;
`endif
  modport master (
    input cand_valid_i, cand_vars_i, mem_break_i, mem_mask_i,
    output cand_ready_o, mem_rd_o, mem_addr_o, clause_broken_o, mask_bits_o, wren_o,
      break_values_valid_o, result_ready_o
`ifdef BFS_STATS_EN
    , output stats_sets_o, stats_short_o
`endif
  );
  modport slave (
    output cand_valid_i, cand_vars_i, mem_break_i, mem_mask_i,
    input cand_ready_o, mem_rd_o, mem_addr_o, clause_broken_o, mask_bits_o, wren_o,
      break_values_valid_o, result_ready_o
`ifdef BFS_STATS_EN
    , input stats_sets_o, stats_short_o
`endif
  );
endinterface

// File: rtl/break_fetch_sequencer.sv
// break_fetch_sequencer: fetches three candidates' break/mask words and drives the selector load sequence (BFS_STATS_EN adds set counters)
module break_fetch_sequencer
  import break_fetch_sequencer_pkg::*;
(
  input logic clk,
  input logic reset,
  break_fetch_sequencer_if.master bus
);
  state_t state_q, state_d;
  logic [NSAT*VAR_BITS-1:0] vars_q, vars_d;
  logic accept, ld, live, rd;
  logic [1:0] ld_slot, rd_slot;
  // state register and candidate latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vars_q <= '0;
    end else begin
      state_q <= state_d;
      vars_q <= vars_d;
    end
  end
  // next state and Moore outputs; slot data is passed through from memory in LD states
  always_comb begin
    accept = bus.cand_valid_i && state_q == IDLE;
    vars_d = accept ? bus.cand_vars_i : vars_q;
    state_d = state_q == IDLE ? (accept ? RD0 : IDLE) :
              state_q == RD0 ? LD1 :
              state_q == LD1 ? LD2 :
              state_q == LD2 ? LD3 :
              state_q == LD3 ? DONE : IDLE;
    ld = state_q == LD1 || state_q == LD2 || state_q == LD3;
    ld_slot = state_q == LD1 ? 2'd0 : state_q == LD2 ? 2'd1 : 2'd2;
    live = ld && slot_var(vars_q, ld_slot) != '0;
    rd = state_q == RD0 || state_q == LD1 || state_q == LD2;
    rd_slot = state_q == RD0 ? 2'd0 : state_q == LD1 ? 2'd1 : 2'd2;
  end
  assign bus.cand_ready_o = state_q == IDLE;
  assign bus.mem_rd_o = rd;
  assign bus.mem_addr_o = rd ? slot_var(vars_q, rd_slot) : '0;
  assign bus.clause_broken_o = live ? bus.mem_break_i : '0;
  assign bus.mask_bits_o = live ? bus.mem_mask_i : '0;
  assign bus.wren_o = state_q == LD1 ? WREN_S1 : state_q == LD2 ? WREN_S2 : state_q == LD3 ? WREN_S3 : WREN_NONE;
  assign bus.break_values_valid_o = state_q == LD3 ?
    {slot_var(vars_q, 2'd2) != '0, slot_var(vars_q, 2'd1) != '0, slot_var(vars_q, 2'd0) != '0} : '0;
  assign bus.result_ready_o = state_q == DONE;
`ifdef BFS_STATS_EN
  logic [31:0] sets_q, short_q;
  // accepted-set and short-clause counters, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sets_q <= '0;
      short_q <= '0;
    end else if (accept) begin
      sets_q <= sets_q + 32'd1;
      short_q <= short_q + {31'd0, has_short(bus.cand_vars_i)};
    end
  end
  assign bus.stats_sets_o = sets_q;
  assign bus.stats_short_o = short_q;
`endif
endmodule

// File: tb/tb_break_fetch_sequencer.sv
// tb_break_fetch_sequencer: scoreboard bench with a synchronous clause memory model
module tb_break_fetch_sequencer;
  import break_fetch_sequencer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  break_fetch_sequencer_if bus();
  break_fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {int c; logic [VAR_BITS-1:0] a;} rd_t;
  typedef struct {int c; logic [1:0] w; logic [MC-1:0] cb; logic [MC-1:0] mb; logic [2:0] v;} ld_t;
  rd_t rd_q[$];
  ld_t ld_q[$];
  int rr_q[$];
  int vec = 0, err = 0, cyc = 0, la = -100, acc_cnt = 0, acc_prev = -1, acc_last = -1;
  int st_sets = 0, st_short = 0;
  bit cmem = 1'b0;
  logic [MC-1:0] mbrk = '0, mmsk = '0;
  rd_t r;
  ld_t l;
  int rc;
  logic [VAR_BITS-1:0] cv [3];
  logic [2:0] vv;
  assign bus.mem_break_i = mbrk;
  assign bus.mem_mask_i = mmsk;
  function automatic logic [MC-1:0] fb(input logic [VAR_BITS-1:0] a);
    return cmem ? 20'h00200 : {a[7:0], a};
  endfunction
  function automatic logic [MC-1:0] fm(input logic [VAR_BITS-1:0] a);
    return cmem ? 20'hFFFFF : ~{a, a[11:4]};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_rd_o) begin
    mbrk <= fb(bus.mem_addr_o);
    mmsk <= fm(bus.mem_addr_o);
  end
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_outs", {4'd0, bus.cand_ready_o, bus.mem_rd_o, bus.mem_addr_o, bus.clause_broken_o, bus.mask_bits_o,
        bus.wren_o, bus.break_values_valid_o, bus.result_ready_o}, {4'd0, 1'b1, 1'b0, 12'd0, 20'd0, 20'd0, 2'd0, 3'd0, 1'b0});
      rd_q.delete();
      ld_q.delete();
      rr_q.delete();
      la = -100;
      st_sets = 0;
      st_short = 0;
    end else begin
      chk("ready", 64'(bus.cand_ready_o), 64'(cyc >= la + 6));
      if (bus.mem_rd_o) begin
        if (rd_q.size() == 0) chk("rd_extra", 1, 0);
        else begin
          r = rd_q.pop_front();
          chk("rd_cyc", 64'(cyc), 64'(r.c));
          chk("rd_addr", 64'(bus.mem_addr_o), 64'(r.a));
        end
      end
      if (bus.wren_o != 2'b00) begin
        if (ld_q.size() == 0) chk("wren_extra", 64'(bus.wren_o), 0);
        else begin
          l = ld_q.pop_front();
          chk("ld_cyc", 64'(cyc), 64'(l.c));
          chk("ld_wren", 64'(bus.wren_o), 64'(l.w));
          chk("ld_break", 64'(bus.clause_broken_o), 64'(l.cb));
          chk("ld_mask", 64'(bus.mask_bits_o), 64'(l.mb));
          chk("ld_valid", 64'(bus.break_values_valid_o), 64'(l.v));
        end
      end else chk("idle_data", {bus.clause_broken_o, bus.mask_bits_o, bus.break_values_valid_o}, 0);
      if (bus.result_ready_o) begin
        if (rr_q.size() == 0) chk("rr_extra", 1, 0);
        else begin
          rc = rr_q.pop_front();
          chk("rr_cyc", 64'(cyc), 64'(rc));
        end
      end
`ifdef BFS_STATS_EN
      chk("stats_sets", 64'(bus.stats_sets_o), 64'(st_sets));
      chk("stats_short", 64'(bus.stats_short_o), 64'(st_short));
`endif
      if (bus.cand_valid_i && bus.cand_ready_o) begin
        for (int k = 0; k < 3; k++) cv[k] = bus.cand_vars_i[k*VAR_BITS +: VAR_BITS];
        vv = {cv[2] != 0, cv[1] != 0, cv[0] != 0};
        for (int k = 0; k < 3; k++) begin
          rd_q.push_back('{cyc + 1 + k, cv[k]});
          ld_q.push_back('{cyc + 2 + k, 2'(k + 1), cv[k] != 0 ? fb(cv[k]) : '0, cv[k] != 0 ? fm(cv[k]) : '0,
            k == 2 ? vv : 3'd0});
        end
        rr_q.push_back(cyc + 5);
        la = cyc;
        acc_prev = acc_last;
        acc_last = cyc;
        acc_cnt++;
        st_sets++;
        if (vv != 3'b111) st_short++;
      end
    end
  end
  task automatic send(input logic [NSAT*VAR_BITS-1:0] v);
    bit ok = 1'b0;
    bus.cand_vars_i = v;
    bus.cand_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cand_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_to", 0, 1);
    @(posedge clk);
    #1;
    bus.cand_valid_i = 1'b0;
    bus.cand_vars_i = 36'({$urandom, $urandom});
  endtask
  task automatic wait_idle();
    repeat (7) @(posedge clk);
    #1;
  endtask
  initial begin
    int n0;
    bit seen;
    bus.cand_valid_i = 1'b0;
    bus.cand_vars_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cmem = 1'b1;
    send({12'd17, 12'd9, 12'd5});
    send({12'd17, 12'd9, 12'd0});
    wait_idle();
    cmem = 1'b0;
    send({12'd300, 12'd4095, 12'd1});
    send({12'd0, 12'd0, 12'd0});
    send({12'd0, 12'd77, 12'd0});
    for (int i = 0; i < 4; i++) send(36'({$urandom, $urandom}));
    wait_idle();
    n0 = acc_cnt;
    bus.cand_vars_i = {12'd33, 12'd22, 12'd11};
    bus.cand_valid_i = 1'b1;
    repeat (12) @(posedge clk);
    #1 bus.cand_valid_i = 1'b0;
    chk("hold_accepts", 64'(acc_cnt - n0), 2);
    chk("hold_gap", 64'(acc_last - acc_prev), 6);
    wait_idle();
    send({12'd3, 12'd2, 12'd1});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.wren_o == 2'b10) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ld2_seen", 64'(seen), 1);
    #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send({12'd8, 12'd0, 12'd6});
    send({12'd100, 12'd200, 12'd300});
    wait_idle();
    chk("q_empty", 64'(rd_q.size() + ld_q.size() + rr_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
